// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC unit: RV32I opcodes that the
// pre-decoder recognises, the fetch FSM state enum and the default reset PC.
package fetch_pkg;

   localparam logic [6:0]  OPC_BRANCH       = 7'b1100011;
   localparam logic [6:0]  OPC_JAL          = 7'b1101111;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [0:0] {
      RUN           = 1'b0,
      HOLD_REDIRECT = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-side bundle between the PC unit (slave) and its environment (master).
// There is no valid/ready pair: inputs are sampled every cycle and
// instr_valid_o qualifies the fetched word.
interface fetch_pc_unit_if;
   logic        stall_i;
   logic        icache_stall_i;
   logic [31:0] instr_i;
   logic        take_branch_i;
   logic        mispredict_i;
   logic [31:0] correct_pc_i;
   logic [31:0] pc_o;
   logic [31:0] branch_pc_o;
   logic        is_branch_o;
   logic        pred_taken_o;
   logic        instr_valid_o;

   modport slave (
      input  stall_i, icache_stall_i, instr_i, take_branch_i, mispredict_i, correct_pc_i,
      output pc_o, branch_pc_o, is_branch_o, pred_taken_o, instr_valid_o
   );

   modport master (
      output stall_i, icache_stall_i, instr_i, take_branch_i, mispredict_i, correct_pc_i,
      input  pc_o, branch_pc_o, is_branch_o, pred_taken_o, instr_valid_o
   );
endinterface

// File: rtl/fetch_predecode.sv
// Combinational RV32I pre-decode: flags conditional branches (and JAL when
// JAL_EN is set) and produces the sign-extended PC-relative immediate.
module fetch_predecode
   import fetch_pkg::*;
#(
   parameter bit JAL_EN = 1'b0
) (
   input  logic [31:0] instr_i,
   output logic        is_branch_o,
   output logic        is_jal_o,
   output logic [31:0] imm_o
);

   logic        is_b;
   logic [31:0] b_imm;
   logic [31:0] j_imm;

   always_comb begin
      is_b     = (instr_i[6:0] == OPC_BRANCH);
      is_jal_o = (instr_i[6:0] == OPC_JAL);
      b_imm    = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      j_imm    = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      imm_o    = is_jal_o ? j_imm : b_imm;
      is_branch_o = is_b | (is_jal_o & JAL_EN);
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator: owns the fetch address, steers to predicted branch
// targets and applies EX redirects. JAL pre-decode via FETCH_JAL_PREDECODE_EN.
module fetch_pc_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic             clk,
   input  logic             rst,
   fetch_pc_unit_if.slave   bus,
   output fetch_state_t     state_dbg_o
);

`ifdef FETCH_JAL_PREDECODE_EN
   localparam bit JAL_EN = 1'b1;
`else
   localparam bit JAL_EN = 1'b0;
`endif

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  buf_q, buf_d;
   logic         pd_is_branch;
   logic         pd_is_jal;
   logic [31:0]  pd_imm;
   logic         instr_valid;
   logic         is_branch;
   logic         pred_taken;

   fetch_predecode #(.JAL_EN(JAL_EN)) u_predecode (
      .instr_i     (bus.instr_i),
      .is_branch_o (pd_is_branch),
      .is_jal_o    (pd_is_jal),
      .imm_o       (pd_imm)
   );

   // Decode outputs are qualified by instr_valid so wrong-path words never predict.
   always_comb begin
      instr_valid = (state_q == RUN) & ~bus.icache_stall_i & ~bus.mispredict_i & ~rst;
      is_branch   = instr_valid & pd_is_branch;
      pred_taken  = is_branch & (bus.take_branch_i | (pd_is_jal & JAL_EN));
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      buf_d   = buf_q;
      case (state_q)
         RUN: begin
            if (bus.mispredict_i && !bus.icache_stall_i) begin
               pc_d = bus.correct_pc_i;
            end else if (bus.mispredict_i) begin
               buf_d   = bus.correct_pc_i;
               state_d = HOLD_REDIRECT;
            end else if (bus.stall_i || bus.icache_stall_i) begin
               pc_d = pc_q;
            end else if (pred_taken) begin
               pc_d = pc_q + pd_imm;
            end else begin
               pc_d = pc_q + 32'd4;
            end
         end
         HOLD_REDIRECT: begin
            if (bus.mispredict_i) begin
               buf_d = bus.correct_pc_i;
            end
            // A redirect arriving on the release cycle is the newest one.
            if (!bus.icache_stall_i) begin
               pc_d    = bus.mispredict_i ? bus.correct_pc_i : buf_q;
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         buf_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         buf_q   <= buf_d;
      end
   end

   assign bus.pc_o          = pc_q;
   assign bus.branch_pc_o   = pc_q;
   assign bus.is_branch_o   = is_branch;
   assign bus.pred_taken_o  = pred_taken;
   assign bus.instr_valid_o = instr_valid;
   assign state_dbg_o       = state_q;

endmodule
